// File: rtl/sprite_region_capture.sv
// Copies a WIDTH x HEIGHT screen rectangle from the framebuffer into a local save RAM, in row-major order.
// Off-screen pixels are not read from the framebuffer and are stored as colour 0.
module sprite_region_capture #(
    parameter int WIDTH    = 36,
    parameter int HEIGHT   = 28,
    parameter int ADDR_W   = 10,
    parameter int SCREEN_W = 320,
    parameter int SCREEN_H = 240
) (
    input  logic              clock_all,
    input  logic              reset_all,
    input  logic              start,
    input  logic [8:0]        x_,
    input  logic [7:0]        y_,
    output logic              fb_rd_en,
    output logic [8:0]        fb_rd_x,
    output logic [7:0]        fb_rd_y,
    input  logic [2:0]        fb_rd_data,
    output logic              buf_wren,
    output logic [ADDR_W-1:0] buf_addr,
    output logic [2:0]        buf_data,
    output logic              busy,
    output logic              done
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam logic [9:0] SCREEN_W_L = 10'(SCREEN_W);
    localparam logic [8:0] SCREEN_H_L = 9'(SCREEN_H);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t            state_q, state_d;
    logic [8:0]        x_lat_q, x_lat_d;
    logic [7:0]        y_lat_q, y_lat_d;
    logic [CW-1:0]     col_q, col_d;
    logic [RW-1:0]     row_q, row_d;
    logic [ADDR_W-1:0] pix_q, pix_d;

    logic              iss_en_q, iss_en_d;
    logic              iss_vld_q, iss_vld_d;
    logic [8:0]        iss_x_q, iss_x_d;
    logic [7:0]        iss_y_q, iss_y_d;
    logic [ADDR_W-1:0] iss_pix_q, iss_pix_d;

    logic              wr_vld_q, wr_vld_d;
    logic              wr_in_q, wr_in_d;
    logic [ADDR_W-1:0] wr_pix_q, wr_pix_d;

    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [9:0]        sum_x;
    logic [8:0]        sum_y;

    always_comb begin
        state_d = state_q;
        x_lat_d = x_lat_q;
        y_lat_d = y_lat_q;
        col_d   = col_q;
        row_d   = row_q;
        pix_d   = pix_q;

        sum_x = {1'b0, x_lat_q} + 10'(col_q);
        sum_y = {1'b0, y_lat_q} + 9'(row_q);

        case (state_q)
            IDLE: begin
                if (start) begin
                    x_lat_d = x_;
                    y_lat_d = y_;
                    col_d   = '0;
                    row_d   = '0;
                    pix_d   = '0;
                    state_d = READ;
                end
            end
            READ: begin
                pix_d = pix_q + ADDR_W'(1);
                if (col_q == CW'(WIDTH - 1)) begin
                    col_d = '0;
                    if (row_q == RW'(HEIGHT - 1)) begin
                        row_d   = '0;
                        state_d = DRAIN;
                    end else begin
                        row_d = row_q + RW'(1);
                    end
                end else begin
                    col_d = col_q + CW'(1);
                end
            end
            DRAIN:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Read-issue stage: the pixel the FSM is on this cycle appears on the read port next cycle.
        iss_vld_d = (state_q == READ);
        iss_en_d  = iss_vld_d && (sum_x < SCREEN_W_L) && (sum_y < SCREEN_H_L);
        iss_x_d   = iss_vld_d ? sum_x[8:0] : 9'd0;
        iss_y_d   = iss_vld_d ? sum_y[7:0] : 8'd0;
        iss_pix_d = iss_vld_d ? pix_q : '0;

        // Write stage lines up with the framebuffer's one-cycle read latency.
        wr_vld_d = iss_vld_q;
        wr_in_d  = iss_en_q;
        wr_pix_d = iss_pix_q;

        done_d = (state_q == DONE);
        busy_d = (state_d != IDLE) || (state_q == DONE);
    end

    always_ff @(posedge clock_all) begin
        if (!reset_all) begin
            state_q   <= IDLE;
            x_lat_q   <= '0;
            y_lat_q   <= '0;
            col_q     <= '0;
            row_q     <= '0;
            pix_q     <= '0;
            iss_en_q  <= 1'b0;
            iss_vld_q <= 1'b0;
            iss_x_q   <= '0;
            iss_y_q   <= '0;
            iss_pix_q <= '0;
            wr_vld_q  <= 1'b0;
            wr_in_q   <= 1'b0;
            wr_pix_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_lat_q   <= x_lat_d;
            y_lat_q   <= y_lat_d;
            col_q     <= col_d;
            row_q     <= row_d;
            pix_q     <= pix_d;
            iss_en_q  <= iss_en_d;
            iss_vld_q <= iss_vld_d;
            iss_x_q   <= iss_x_d;
            iss_y_q   <= iss_y_d;
            iss_pix_q <= iss_pix_d;
            wr_vld_q  <= wr_vld_d;
            wr_in_q   <= wr_in_d;
            wr_pix_q  <= wr_pix_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign fb_rd_en = iss_en_q;
    assign fb_rd_x  = iss_x_q;
    assign fb_rd_y  = iss_y_q;
    assign buf_wren = wr_vld_q;
    assign buf_addr = wr_pix_q;
    assign buf_data = wr_in_q ? fb_rd_data : 3'b000;
    assign busy     = busy_q;
    assign done     = done_q;
endmodule

// File: tb/tb_sprite_region_capture.sv
// Directed bench for sprite_region_capture: framebuffer model returns (x+y)%8, writes are logged into a save-RAM image.
module tb_sprite_region_capture;
    localparam int W = 36;
    localparam int H = 28;
    localparam int N = W * H;

    logic       clk = 1'b0;
    logic       reset_all = 1'b0;
    logic       start = 1'b0;
    logic [8:0] x_ = '0;
    logic [7:0] y_ = '0;
    logic       fb_rd_en;
    logic [8:0] fb_rd_x;
    logic [7:0] fb_rd_y;
    logic [2:0] fb_rd_data = '0;
    logic       buf_wren;
    logic [9:0] buf_addr;
    logic [2:0] buf_data;
    logic       busy;
    logic       done;

    always #5 clk = ~clk;

    sprite_region_capture #(
        .WIDTH(W), .HEIGHT(H), .ADDR_W(10), .SCREEN_W(320), .SCREEN_H(240)
    ) dut (
        .clock_all (clk),
        .reset_all (reset_all),
        .start     (start),
        .x_        (x_),
        .y_        (y_),
        .fb_rd_en  (fb_rd_en),
        .fb_rd_x   (fb_rd_x),
        .fb_rd_y   (fb_rd_y),
        .fb_rd_data(fb_rd_data),
        .buf_wren  (buf_wren),
        .buf_addr  (buf_addr),
        .buf_data  (buf_data),
        .busy      (busy),
        .done      (done)
    );

    // Synchronous framebuffer; a poison colour appears when not strobed so unmasked clipped writes show up.
    logic [9:0] fb_sum;
    always @(posedge clk) begin
        fb_sum = {1'b0, fb_rd_x} + {2'b00, fb_rd_y};
        if (fb_rd_en) fb_rd_data <= fb_sum[2:0];
        else          fb_rd_data <= 3'd5;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [3:0] mem [0:1023];
    int wr_cnt, strobe_cnt, done_cnt, order_err, clip_err, done_cyc, gap, pend, busy_hi;

    always @(negedge clk) begin
        if (busy) busy_hi++;
        if (buf_wren) begin
            if (int'(buf_addr) != (wr_cnt % N)) order_err++;
            mem[buf_addr] = {1'b0, buf_data};
            wr_cnt++;
        end
        if (fb_rd_en) begin
            strobe_cnt++;
            if (fb_rd_x >= 9'd320 || fb_rd_y >= 8'd240) clip_err++;
            if (pend != 0) begin
                gap  = cyc - done_cyc;
                pend = 0;
            end
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            pend     = 1;
        end
    end

    int total = 0;
    int bad   = 0;
    int t0    = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_sb();
        for (int i = 0; i < 1024; i++) mem[i] = 4'hF;
        wr_cnt = 0; strobe_cnt = 0; done_cnt = 0; order_err = 0;
        clip_err = 0; done_cyc = 0; gap = -1; pend = 0; busy_hi = 0;
    endtask

    task automatic do_start(input int x, input int y, input bit hold);
        @(negedge clk);
        x_    = 9'(x);
        y_    = 8'(y);
        start = 1'b1;
        @(posedge clk);
        #1;
        t0 = cyc;
        if (!hold) start = 1'b0;
    endtask

    task automatic wait_done(input int ndone, input int budget, input int poke, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (i == poke) begin
                start = 1'b1;
                x_    = 9'd100;
                y_    = 8'd7;
            end else if (i == poke + 1) begin
                start = 1'b0;
            end
            if (done_cnt >= ndone) begin
                ok = 1'b1;
                break;
            end
        end
        start = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    typedef struct {
        int x;
        int y;
        int strobes;
    } vec_t;

    typedef struct {
        int rec;
        int addr;
        int data;
    } probe_t;

    vec_t   vecs   [5];
    probe_t probes [20];

    task automatic check_probes(input int rec, input string tag);
        for (int p = 0; p < 20; p++) begin
            if (probes[p].rec == rec)
                check($sformatf("%s addr%0d", tag, probes[p].addr),
                      int'(mem[probes[p].addr]), probes[p].data);
        end
    endtask

    task automatic check_capture(input int rec, input string tag, input bit ok);
        check({tag, " timeout"}, int'(ok), 1);
        check({tag, " writes"}, wr_cnt, N);
        check({tag, " strobes"}, strobe_cnt, vecs[rec].strobes);
        check({tag, " done_count"}, done_cnt, 1);
        check({tag, " done_latency"}, done_cyc - t0, N + 2);
        check({tag, " order_errors"}, order_err, 0);
        check({tag, " clip_errors"}, clip_err, 0);
        check_probes(rec, tag);
        $display("capture %s x=%0d y=%0d writes=%0d strobes=%0d dones=%0d latency=%0d",
                 tag, vecs[rec].x, vecs[rec].y, wr_cnt, strobe_cnt, done_cnt, done_cyc - t0);
    endtask

    initial begin
        bit ok;
        int w_at_rst;

        vecs[0] = '{x: 10,  y: 20,  strobes: 1008};
        vecs[1] = '{x: 300, y: 230, strobes: 200};
        vecs[2] = '{x: 0,   y: 0,   strobes: 1008};
        vecs[3] = '{x: 511, y: 255, strobes: 0};
        vecs[4] = '{x: 290, y: 0,   strobes: 840};

        probes[0]  = '{rec: 0, addr: 0,    data: 6};
        probes[1]  = '{rec: 0, addr: 35,   data: 1};
        probes[2]  = '{rec: 0, addr: 36,   data: 7};
        probes[3]  = '{rec: 0, addr: 1007, data: 4};
        probes[4]  = '{rec: 1, addr: 19,   data: 5};
        probes[5]  = '{rec: 1, addr: 20,   data: 0};
        probes[6]  = '{rec: 1, addr: 343,  data: 6};
        probes[7]  = '{rec: 1, addr: 360,  data: 0};
        probes[8]  = '{rec: 2, addr: 0,    data: 0};
        probes[9]  = '{rec: 2, addr: 37,   data: 2};
        probes[10] = '{rec: 2, addr: 500,  data: 5};
        probes[11] = '{rec: 2, addr: 1007, data: 6};
        probes[12] = '{rec: 3, addr: 0,    data: 0};
        probes[13] = '{rec: 3, addr: 100,  data: 0};
        probes[14] = '{rec: 3, addr: 500,  data: 0};
        probes[15] = '{rec: 3, addr: 1007, data: 0};
        probes[16] = '{rec: 4, addr: 29,   data: 7};
        probes[17] = '{rec: 4, addr: 30,   data: 0};
        probes[18] = '{rec: 4, addr: 38,   data: 5};
        probes[19] = '{rec: 4, addr: 1007, data: 0};

        clear_sb();
        reset_all = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_all = 1'b1;
        check("reset outputs",
              int'({fb_rd_en, fb_rd_x, fb_rd_y, buf_wren, buf_addr, buf_data, busy, done}), 0);
        repeat (20) @(negedge clk);
        check("idle busy cycles", busy_hi, 0);
        check("idle writes", wr_cnt, 0);
        $display("reset/idle: busy_cycles=%0d writes=%0d", busy_hi, wr_cnt);

        for (int r = 0; r < 5; r++) begin
            clear_sb();
            do_start(vecs[r].x, vecs[r].y, 1'b0);
            check($sformatf("vec%0d busy_after_start", r), int'(busy), 1);
            wait_done(1, 1200, -10, ok);
            check($sformatf("vec%0d busy_after_done", r), int'(busy), 0);
            check_capture(r, $sformatf("vec%0d", r), ok);
        end

        clear_sb();
        do_start(10, 20, 1'b0);
        wait_done(1, 1200, 500, ok);
        check_capture(0, "start_while_busy", ok);

        clear_sb();
        do_start(10, 20, 1'b0);
        repeat (299) @(negedge clk);
        reset_all = 1'b0;
        @(negedge clk);
        check("midreset busy", int'(busy), 0);
        check("midreset wren", int'(buf_wren), 0);
        w_at_rst  = wr_cnt;
        reset_all = 1'b1;
        repeat (1100) @(negedge clk);
        check("midreset no_done", done_cnt, 0);
        check("midreset no_more_writes", wr_cnt, w_at_rst);
        check("midreset partial", int'(w_at_rst > 250 && w_at_rst < 350), 1);
        $display("mid-capture reset: writes_before=%0d writes_after=%0d dones=%0d",
                 w_at_rst, wr_cnt, done_cnt);
        clear_sb();
        do_start(10, 20, 1'b0);
        wait_done(1, 1200, -10, ok);
        check_capture(0, "after_reset", ok);

        clear_sb();
        do_start(10, 20, 1'b1);
        ok = 1'b0;
        for (int i = 0; i < 2500; i++) begin
            @(negedge clk);
            #1;
            if (done_cnt >= 2) begin
                ok = 1'b1;
                break;
            end
        end
        start = 1'b0;
        repeat (10) @(negedge clk);
        check("b2b timeout", int'(ok), 1);
        check("b2b done_count", done_cnt, 2);
        check("b2b writes", wr_cnt, 2 * N);
        check("b2b strobes", strobe_cnt, 2 * N);
        check("b2b gap", gap, 2);
        check("b2b order_errors", order_err, 0);
        check_probes(0, "b2b");
        $display("back-to-back: dones=%0d writes=%0d strobes=%0d gap=%0d",
                 done_cnt, wr_cnt, strobe_cnt, gap);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sprite_region_capture.md
Name: sprite_region_capture

Overview:
- Reader-side counterpart of the sprite draw blocks. Draw blocks stream ROM pixels onto the screen; this block reads a WIDTH x HEIGHT screen rectangle back out of the framebuffer.
- It copies that rectangle into a sprite-sized local RAM in row-major order.
- Used to save the background under a battle sprite before it is drawn, so the background can be restored later.
- Sits between the battle controller (start/done) and the framebuffer read port and save-RAM write port.

Parameters:
- WIDTH, 36, rectangle width in pixels.
- HEIGHT, 28, rectangle height in pixels.
- ADDR_W, 10, save-RAM address width. Must satisfy 2^ADDR_W >= WIDTH*HEIGHT.
- SCREEN_W, 320, visible screen width; used for clipping.
- SCREEN_H, 240, visible screen height; used for clipping.

Ports:
- clock_all, input, 1, system clock. All logic is on the rising edge.
- reset_all, input, 1, synchronous active-low reset.
- start, input, 1, capture request. Sampled only in IDLE.
- x_, input, 9, rectangle origin column. Latched on an accepted start.
- y_, input, 8, rectangle origin row. Latched on an accepted start.
- fb_rd_en, output, 1, framebuffer read strobe.
- fb_rd_x, output, 9, framebuffer read column.
- fb_rd_y, output, 8, framebuffer read row.
- fb_rd_data, input, 3, framebuffer colour. Valid exactly 1 cycle after the strobe (synchronous RAM).
- buf_wren, output, 1, save-RAM write enable.
- buf_addr, output, ADDR_W, save-RAM write address.
- buf_data, output, 3, save-RAM write colour.
- busy, output, 1, high while a capture is in progress.
- done, output, 1, single-cycle completion pulse.

Behaviour:
- Reset (reset_all==0 at a clock edge):
  - State returns to IDLE; latched origin and counters are cleared.
  - All outputs go to 0.
  - Reset mid-capture aborts immediately. No further buf_wren and no done pulse for the aborted capture.
- States: IDLE, READ, DRAIN, DONE.
- IDLE:
  - busy=0, fb_rd_en=0, buf_wren=0.
  - start=1 latches x_/y_, clears col/row/pixel index, and moves to READ.
- READ (lasts exactly N=WIDTH*HEIGHT cycles):
  - Each cycle issues pixel k = row*WIDTH + col.
  - fb_rd_x = x_lat + col and fb_rd_y = y_lat + row. The sums are computed 10/9 bits wide, then truncated to the port widths.
  - fb_rd_en = 1 only if x_lat+col < SCREEN_W and y_lat+row < SCREEN_H. Otherwise the pixel is clipped and fb_rd_en = 0.
  - col increments each cycle. When col==WIDTH-1, col wraps to 0 and row increments.
  - After pixel N-1 (col==WIDTH-1, row==HEIGHT-1) the state goes to DRAIN.
- Write pipeline:
  - The write for pixel k occurs exactly 1 cycle after its issue.
  - buf_wren=1, buf_addr=k.
  - buf_data = fb_rd_data if pixel k was in-screen, else 3'b000.
  - Index and clip flag are carried through a 1-stage register.
  - Every one of the N addresses 0..N-1 is written exactly once, in increasing order, with no gaps.
- DRAIN (1 cycle): performs the write of pixel N-1; no read is issued.
- DONE (1 cycle): done=1, no write, then IDLE.
- Overall timing: busy=1 in READ, DRAIN and DONE. With start accepted at edge 0, capture occupies N+2 cycles and done is high in the cycle after edge N+2.
- start while busy is ignored; the capture is not restarted.
- start held high in IDLE immediately after DONE begins a new capture with no idle gap beyond the one IDLE cycle.
- x_/y_ changes during a capture have no effect.

Test Plan:
- Reset and idle: reset_all=0 for 2 cycles, then release with start=0 -> all outputs 0, busy=0 indefinitely.
- Basic capture: x_=10, y_=20, framebuffer model returns colour=(x+y)%8; pulse start.
  - First strobe reads (10,20); buf_addr 0 receives 3'd6.
  - buf_addr 35 receives (45+20)%8 = 3'd1; buf_addr 36 receives (10+21)%8 = 3'd7.
  - Last write is buf_addr 1007 = (45+47)%8 = 3'd4.
  - Exactly 1008 writes; done pulses once, 1010 cycles after the start edge.
- Right/bottom clipping: x_=300, y_=230.
  - Columns 20..35 and rows 10..27 are never strobed and are written as 3'b000.
  - buf_addr 19 holds framebuffer(319,230); buf_addr 20 holds 0.
- Start while busy: pulse start again at cycle 500 with a different x_ -> ignored; addresses and data unchanged; one done pulse only.
- Reset mid-capture: assert reset_all at cycle 300 -> next cycle busy=0 and buf_wren=0; no done. A new start afterwards runs a full 1008-write capture.
- Back-to-back: start held high continuously -> second capture's first strobe occurs 2 cycles after the first done (DONE then IDLE). Both captures are complete.
